// File: rtl/y_pulse_meter_pkg.sv
// Shared definitions for the Y pulse-length meter: state encoding and default widths.
package y_pulse_meter_pkg;

  localparam int unsigned DEF_CNT_W  = 8;
  localparam int unsigned DEF_PCNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: load1 restarts at 1, inc counts up and holds at all-ones,
// raising sat on any increment attempted while already full.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (load1) begin
      q   <= W'(1);
      sat <= 1'b0;
    end else if (inc) begin
      if (&q) sat <= 1'b1;
      else    q   <= q + W'(1);
    end
  end

endmodule

// File: rtl/y_pulse_meter.sv
// Measures the length of each high pulse on y_in and presents it on a
// valid/ready output register with saturation, sticky drop and a pulse count.
module y_pulse_meter
  import y_pulse_meter_pkg::*;
#(
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned PCNT_W = DEF_PCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              y_in,
  input  logic              clr,
  output logic              len_valid,
  input  logic              len_ready,
  output logic [CNT_W-1:0]  len_data,
  output logic              len_sat,
  output logic              drop,
  output logic [PCNT_W-1:0] pulse_cnt
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_sat;
  logic             load1;
  logic             inc;
  logic             done;

  assign load1 = (state == ST_IDLE) && y_in;
  assign inc   = (state == ST_RUN) && y_in;
  assign done  = (state == ST_RUN) && !y_in;

  sat_counter #(.W(CNT_W)) u_len_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load1 (load1),
    .inc   (inc),
    .q     (cnt),
    .sat   (cnt_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      len_valid <= 1'b0;
      len_data  <= '0;
      len_sat   <= 1'b0;
      drop      <= 1'b0;
      pulse_cnt <= '0;
    end else if (clr) begin
      state     <= ST_IDLE;
      len_valid <= 1'b0;
      len_data  <= '0;
      len_sat   <= 1'b0;
      drop      <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (y_in)  state <= ST_RUN;
        ST_RUN:  if (!y_in) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // A completion may reuse the slot freed by a same-cycle handshake.
      if (done) begin
        pulse_cnt <= pulse_cnt + PCNT_W'(1);
        if (!len_valid || len_ready) begin
          len_data  <= cnt;
          len_sat   <= cnt_sat;
          len_valid <= 1'b1;
        end else begin
          drop <= 1'b1;
        end
      end else if (len_valid && len_ready) begin
        len_valid <= 1'b0;
      end
    end
  end

endmodule
